// File: rtl/tf_fifo_feeder_if.sv
// ROM read port and FIFO write port of the twiddle-factor feeder.
// Address width is kept at least 1 bit so a single-entry table stays legal.
interface tf_fifo_feeder_if #(
   parameter int float_len        = 32,
   parameter int bram_tf_addr_len = 2
);
   localparam int aw = (bram_tf_addr_len > 0) ? bram_tf_addr_len : 1;

   logic [aw-1:0]          tf_rom_addr;
   logic                   tf_rom_en;
   logic [2*float_len-1:0] tf_rom_data;
   logic                   fifo_full;
   logic [2*float_len-1:0] fifo_din;
   logic                   fifo_wr_en;

   modport master (
      output tf_rom_addr, tf_rom_en, fifo_din, fifo_wr_en,
      input  tf_rom_data, fifo_full
   );

   modport slave (
      input  tf_rom_addr, tf_rom_en, fifo_din, fifo_wr_en,
      output tf_rom_data, fifo_full
   );
endinterface

// File: rtl/tf_fifo_feeder.sv
// Streams the twiddle-factor ROM into the stage FIFO pass_num times per start,
// using a one-entry hold register to cover the ROM read latency under backpressure.
module tf_fifo_feeder #(
   parameter int float_len        = 32,
   parameter int bram_tf_addr_len = 2,
   parameter int tf_num           = 4,
   parameter int pass_num         = 2,
   parameter int pass_len         = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   tf_fifo_feeder_if.master  bus,
   output logic              busy,
   output logic              done
);
   localparam int aw = (bram_tf_addr_len > 0) ? bram_tf_addr_len : 1;
   localparam int pw = (pass_len > 0) ? pass_len : 1;
   localparam logic [aw-1:0] addr_last = aw'(tf_num - 1);
   localparam logic [pw-1:0] pass_last = pw'(pass_num - 1);

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t                 state;
   logic [aw-1:0]          addr_cnt;
   logic [pw-1:0]          pass_cnt;
   logic                   issued_all;
   logic                   rd_pending;
   logic                   hold_valid;
   logic [2*float_len-1:0] hold_data;

   logic issue;
   logic wr;

   // A pending read that meets a full FIFO must land in the hold, so no new read then.
   assign issue = (state == RUN) && !issued_all && !hold_valid
                  && !(rd_pending && bus.fifo_full);
   assign wr    = (hold_valid || rd_pending) && !bus.fifo_full && !rst;

   assign bus.tf_rom_en   = issue;
   assign bus.tf_rom_addr = (state == RUN) ? addr_cnt : '0;
   assign bus.fifo_wr_en  = wr;
   assign bus.fifo_din    = hold_valid ? hold_data :
                            rd_pending ? bus.tf_rom_data : '0;

   assign busy = (state == RUN);
   assign done = (state == FINISH);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         addr_cnt   <= '0;
         pass_cnt   <= '0;
         issued_all <= 1'b0;
         rd_pending <= 1'b0;
         hold_valid <= 1'b0;
         hold_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= RUN;
                  addr_cnt   <= '0;
                  pass_cnt   <= '0;
                  issued_all <= 1'b0;
               end
            end
            RUN: begin
               rd_pending <= issue;
               if (issue) begin
                  if (addr_cnt == addr_last) begin
                     addr_cnt <= '0;
                     pass_cnt <= pass_cnt + 1'b1;
                     if (pass_cnt == pass_last)
                        issued_all <= 1'b1;
                  end else begin
                     addr_cnt <= addr_cnt + 1'b1;
                  end
               end
               if (rd_pending && bus.fifo_full) begin
                  hold_data  <= bus.tf_rom_data;
                  hold_valid <= 1'b1;
               end else if (hold_valid && wr) begin
                  hold_valid <= 1'b0;
               end
               // Once everything is issued, only the last word can still be in flight.
               if (wr && issued_all)
                  state <= FINISH;
            end
            FINISH: begin
               state      <= IDLE;
               issued_all <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_tf_fifo_feeder.sv
// Scoreboard bench for tf_fifo_feeder: default instance plus a single-entry instance.
module tb_tf_fifo_feeder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic m_start = 1'b0;
   logic busy, done, m_busy, m_done;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int t0 = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   tf_fifo_feeder_if #(.float_len(32), .bram_tf_addr_len(2)) bus ();
   tf_fifo_feeder_if #(.float_len(32), .bram_tf_addr_len(0)) mbus ();

   tf_fifo_feeder #(
      .float_len(32), .bram_tf_addr_len(2), .tf_num(4), .pass_num(2), .pass_len(2)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .bus(bus), .busy(busy), .done(done)
   );

   tf_fifo_feeder #(
      .float_len(32), .bram_tf_addr_len(0), .tf_num(1), .pass_num(1), .pass_len(1)
   ) mdut (
      .clk(clk), .rst(rst), .start(m_start), .bus(mbus), .busy(m_busy), .done(m_done)
   );

   // ROM word for address a is {a, ~a} (2-bit inverse), each half zero-extended.
   logic [63:0] words [4] = '{64'h0000_0000_0000_0003, 64'h0000_0001_0000_0002,
                              64'h0000_0002_0000_0001, 64'h0000_0003_0000_0000};
   logic [63:0] m_word = 64'h1234_5678_9abc_def0;

   always @(posedge clk)
      if (bus.tf_rom_en) bus.tf_rom_data <= words[bus.tf_rom_addr];
   assign mbus.tf_rom_data = m_word;

   logic [63:0] exp_q [$];
   logic [63:0] m_exp_q [$];
   int wr_log [$];
   int done_log [$];
   int addr_cyc [$];
   int addr_val [$];
   int m_wr_log [$];
   int m_done_log [$];
   int busy_n;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every FIFO write.
   always @(negedge clk) begin
      logic [63:0] e;
      if (!rst) begin
         if (bus.fifo_wr_en) begin
            wr_log.push_back(cyc - t0);
            check("wr_while_full", {63'd0, bus.fifo_full}, 64'd0);
            if (exp_q.size() == 0) begin
               check("unexpected_write", bus.fifo_din, 64'hdead);
            end else begin
               e = exp_q.pop_front();
               check("fifo_din", bus.fifo_din, e);
            end
         end
         if (done) done_log.push_back(cyc - t0);
         if (busy) busy_n++;
         if (bus.tf_rom_en) begin
            addr_cyc.push_back(cyc - t0);
            addr_val.push_back(int'(bus.tf_rom_addr));
         end
         if (mbus.fifo_wr_en) begin
            m_wr_log.push_back(cyc - t0);
            if (m_exp_q.size() == 0) begin
               check("min_unexpected_write", mbus.fifo_din, 64'hdead);
            end else begin
               e = m_exp_q.pop_front();
               check("min_fifo_din", mbus.fifo_din, e);
            end
         end
         if (m_done) m_done_log.push_back(cyc - t0);
         if (mbus.tf_rom_en) check("min_addr", 64'(mbus.tf_rom_addr), 64'd0);
      end
   end

   // mode: 0 plain, 1 full 2..6, 2 alternating full, 3 second start at 4, 4 reset at 5
   task automatic run_test(input int mode, input int ncyc);
      wr_log.delete(); done_log.delete(); addr_cyc.delete(); addr_val.delete();
      busy_n = 0;
      t0 = cyc;
      for (int c = 0; c < ncyc; c++) begin
         start = (c == 0) || (mode == 3 && c == 4);
         if (c == 0)
            for (int p = 0; p < 2; p++)
               for (int a = 0; a < 4; a++) exp_q.push_back(words[a]);
         case (mode)
            1: bus.fifo_full = (c >= 2 && c <= 6);
            2: bus.fifo_full = (c % 2 == 1);
            4: bus.fifo_full = (c >= 4);
            default: bus.fifo_full = 1'b0;
         endcase
         rst = (mode == 4 && c == 5);
         if (mode == 4 && c == 6) begin
            @(negedge clk);
            check("rst_wr_en", {63'd0, bus.fifo_wr_en}, 64'd0);
            check("rst_rom_en", {63'd0, bus.tf_rom_en}, 64'd0);
            check("rst_busy_done", {62'd0, busy, done}, 64'd0);
            check("rst_din", bus.fifo_din, 64'd0);
            check("rst_addr", 64'(bus.tf_rom_addr), 64'd0);
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      bus.fifo_full = 1'b0;
      rst = 1'b0;
   endtask

   task automatic check_common(input string name, input int first_wr);
      check({name, "_wr_count"}, 64'(wr_log.size()), 64'd8);
      if (wr_log.size() > 0) check({name, "_first_wr"}, 64'(wr_log[0]), 64'(first_wr));
      check({name, "_done_count"}, 64'(done_log.size()), 64'd1);
      check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
      if (addr_cyc.size() > 0) begin
         check({name, "_first_issue_cyc"}, 64'(addr_cyc[0]), 64'd1);
         check({name, "_first_issue_addr"}, 64'(addr_val[0]), 64'd0);
      end
   endtask

   initial begin
      int idx;
      bus.fifo_full = 1'b0;
      mbus.fifo_full = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_outputs", {60'd0, bus.fifo_wr_en, bus.tf_rom_en, busy, done}, 64'd0);
      check("reset_din", bus.fifo_din, 64'd0);
      check("reset_addr", 64'(bus.tf_rom_addr), 64'd0);
      @(posedge clk); #1;

      // No backpressure: writes in 2..9, done at 10, busy 1..9
      run_test(0, 14);
      check_common("nobp", 2);
      if (wr_log.size() == 8) check("nobp_last_wr", 64'(wr_log[7]), 64'd9);
      if (done_log.size() == 1) check("nobp_done_cyc", 64'(done_log[0]), 64'd10);
      check("nobp_busy_cycles", 64'(busy_n), 64'd9);

      // Full 2..6: address 0 word written at 7, address 1 issued at 8, done at 16
      run_test(1, 20);
      check_common("stall", 7);
      idx = -1;
      for (int i = 0; i < addr_val.size(); i++)
         if (idx < 0 && addr_val[i] == 1) idx = i;
      check("stall_addr1_found", 64'(idx >= 0), 64'd1);
      if (idx >= 0) check("stall_addr1_cyc", 64'(addr_cyc[idx]), 64'd8);
      if (done_log.size() == 1) check("stall_done_cyc", 64'(done_log[0]), 64'd16);

      // Alternating full
      run_test(2, 30);
      check_common("alt", 2);

      // Second start while busy is ignored, then a fresh start after done
      run_test(3, 14);
      check_common("busy_start", 2);
      if (done_log.size() == 1) check("busy_start_done_cyc", 64'(done_log[0]), 64'd10);
      run_test(0, 14);
      check_common("restart", 2);

      // Reset mid-run with the hold valid
      run_test(4, 10);
      check("rst_wr_count", 64'(wr_log.size()), 64'd2);
      if (wr_log.size() > 0) check("rst_last_wr", 64'(wr_log[wr_log.size()-1]), 64'd3);
      check("rst_discarded", 64'(exp_q.size()), 64'd6);
      check("rst_no_done", 64'(done_log.size()), 64'd0);
      exp_q.delete();
      run_test(0, 14);
      check_common("after_rst", 2);

      // Single-entry, single-pass configuration
      m_wr_log.delete(); m_done_log.delete();
      t0 = cyc;
      m_start = 1'b1;
      m_exp_q.push_back(m_word);
      @(posedge clk); #1;
      m_start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("min_wr_count", 64'(m_wr_log.size()), 64'd1);
      if (m_wr_log.size() == 1) check("min_wr_cyc", 64'(m_wr_log[0]), 64'd2);
      check("min_done_count", 64'(m_done_log.size()), 64'd1);
      if (m_done_log.size() == 1) check("min_done_cyc", 64'(m_done_log[0]), 64'd3);
      check("min_sb_empty", 64'(m_exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
